hazard_scoreboard_unit: RTL and testbench
=========================================

Name: hazard_scoreboard_unit

Overview:
- Next-generation hazard unit for the 5-stage core. Keeps the existing forwarding, load-use, redirect, trap and Wishbone stall/flush network.
- Adds a register scoreboard for long-latency operations (MUL/DIV unit) that complete out of band, with a configurable outstanding-op limit.
- Adds a watchdog that reports a Wishbone bus stalled past a configurable cycle count.
- Sits beside the pipeline registers and drives every stall, flush and forward select.

Parameters:
- NUM_REGS, 32, architectural register count; x0 hard-wired to zero.
- REG_ADDR_W, 5, register address width; must be ≥ clog2(NUM_REGS).
- MAX_PENDING, 4, maximum outstanding long-latency ops (1..NUM_REGS-1).
- BUS_TIMEOUT_CYCLES, 1024, consecutive WISHBONE_BUSY cycles before BUS_TIMEOUT; 0 disables the watchdog.

Ports:
- CLK  in  1  core clock
- RST  in  1  synchronous, active-high reset
- ID_RS1_ADDR, ID_RS2_ADDR, ID_RD_ADDR  in  REG_ADDR_W  decode-stage register addresses
- ID_IS_LONG_OP  in  1  instruction in ID is a long-latency op
- EX_RS1_ADDR, EX_RS2_ADDR, EX_RD_ADDR, MEM_RD_ADDR, WB_RD_ADDR  in  REG_ADDR_W  stage register addresses
- EX_RESULT_SEL, MEM_RESULT_SEL, WB_RESULT_SEL  in  result_sel_t  per-stage result source
- EX_IS_PC_REDIRECT  in  1  taken branch/jump resolved in EX
- EX_TRAP_VALID, MEM_TRAP_VALID, WB_TRAP_VALID  in  1  trap present in stage
- WISHBONE_BUSY  in  1  data-bus transaction outstanding
- LONG_ISSUE_VALID  in  1  long op leaving EX into the MDU this cycle
- LONG_ISSUE_RD  in  REG_ADDR_W  destination of the issued op
- LONG_DONE_VALID  in  1  MDU writing its result to the register file this cycle
- LONG_DONE_RD  in  REG_ADDR_W  destination of the completing op
- EX_FORWARD_A, EX_FORWARD_B  out  3  forward_sel_t operand select for EX
- ID_FORWARD_A, ID_FORWARD_B  out  2  id_fwd_sel_t: 0 none, 1 WB result, 2 MDU done result
- IF_ID_FLUSH, ID_EX_FLUSH, EX_MEM_FLUSH, MEM_WB_FLUSH  out  1  bubble insert
- IF_ID_STALL, ID_EX_STALL, EX_MEM_STALL, MEM_WB_STALL  out  1  hold stage register
- SB_PENDING  out  NUM_REGS  scoreboard pending-write bits
- LONG_COUNT  out  clog2(MAX_PENDING+1)  outstanding long ops
- BUS_TIMEOUT  out  1  one-cycle watchdog pulse

Behaviour:
- Reset values: SB_PENDING=0, LONG_COUNT=0, watchdog counter=0, BUS_TIMEOUT=0. Stall/flush/forward outputs are combinational; during reset only their scoreboard-derived terms are forced to 0.
- EX forwarding, priority order (rs==0 never forwards):
  - MEM rd match → FORWARD_SEL_MEM_ALU_RESULT
  - else WB match with WB_RESULT_SEL=MEM_DATA → FORWARD_SEL_WB_LOAD_RDATA
  - else WB match → FORWARD_SEL_WB_ALU_RESULT
  - else NO_FORWARD_SEL
- ID forwarding, per operand:
  - LONG_DONE_VALID && rs==LONG_DONE_RD && rs≠0 → 2
  - else rs==WB_RD_ADDR && rs≠0 → 1
  - else 0
- load_use: EX_RESULT_SEL==MEM_DATA and a nonzero ID rs1/rs2 equals EX_RD_ADDR.
- done_clr = one-hot(LONG_DONE_RD) when LONG_DONE_VALID, else 0. eff_pending = SB_PENDING & ~done_clr.
- sb_hazard: any of the following, where "nonzero X matches" means X≠0 and eff_pending[X]=1:
  - nonzero ID rs1 matches (RAW)
  - nonzero ID rs2 matches (RAW)
  - nonzero ID rd matches (WAW)
  - ID_IS_LONG_OP && LONG_COUNT==MAX_PENDING (full)
- Stalls:
  - MEM_WB_STALL = WISHBONE_BUSY
  - EX_MEM_STALL = WISHBONE_BUSY | MEM_WB_STALL
  - ID_EX_STALL = EX_MEM_STALL
  - IF_ID_STALL = load_use | sb_hazard | ID_EX_STALL
- Flushes:
  - IF_ID_FLUSH = redirect | any trap in EX/MEM/WB
  - ID_EX_FLUSH = (redirect & ~EX_MEM_STALL) | MEM/WB trap | ((load_use | sb_hazard) & ~ID_EX_STALL) — the last term inserts the bubble behind a held ID
  - EX_MEM_FLUSH = MEM/WB trap
  - MEM_WB_FLUSH = WB trap
- issue_ok = LONG_ISSUE_VALID & LONG_ISSUE_RD≠0 & ~EX_MEM_STALL & ~EX_MEM_FLUSH.
- Scoreboard update each clock: SB_PENDING ← (SB_PENDING & ~done_clr) | (issue_ok ? one-hot(LONG_ISSUE_RD) : 0).
  - Issue and done on the same register in the same cycle: set wins.
  - Bit 0 is never set.
- LONG_COUNT ← LONG_COUNT + issue_ok − done_valid_pending, where done_valid_pending = LONG_DONE_VALID & SB_PENDING[LONG_DONE_RD].
  - A done for a non-pending register is ignored (no underflow).
  - Simultaneous issue and done leaves the count unchanged.
  - Assertion: the count never exceeds MAX_PENDING.
- Issued long ops are not cancelled by traps or redirects; they complete and clear normally.
- Watchdog:
  - Counter increments while WISHBONE_BUSY=1 and clears when it is 0.
  - On reaching BUS_TIMEOUT_CYCLES it pulses BUS_TIMEOUT for exactly one cycle, then saturates with no further pulse until busy drops.
- Mid-operation RST clears all state in one cycle; the MDU is reset alongside and must not signal done afterwards.

Decomposition:
- params_pkg: result_sel_t, forward_sel_t (existing), new id_fwd_sel_t (ID_FWD_NONE/ID_FWD_WB/ID_FWD_LONG).
- Sub-module hazard_scoreboard: pending vector + LONG_COUNT + issue/done update. It exports eff_pending and full; the top keeps the combinational network and the watchdog.

Test Plan:
- Issue x5 (LONG_ISSUE_VALID=1), next cycle ID rs1=5 → IF_ID_STALL=1, ID_EX_FLUSH=1. LONG_DONE_RD=5 → same cycle: stall=0, ID_FORWARD_A=2; next cycle SB_PENDING[5]=0.
- Issue x1..x4 with MAX_PENDING=4, then ID_IS_LONG_OP=1 → stall until one done; LONG_COUNT goes 4→3.
- Same-cycle issue x7 and done x7 → SB_PENDING[7]=1, LONG_COUNT unchanged. Done x9 while not pending → no change.
- Load in EX, rd=3; ID rs2=3 → IF_ID_STALL=1, ID_EX_FLUSH=1. Next cycle WB is the load → EX_FORWARD_B=FORWARD_SEL_WB_LOAD_RDATA.
- WISHBONE_BUSY high 1030 cycles with BUS_TIMEOUT_CYCLES=1024 → exactly one BUS_TIMEOUT pulse, on the 1024th cycle; during busy, EX_IS_PC_REDIRECT=1 gives ID_EX_FLUSH=0.
- MEM_TRAP_VALID=1 with LONG_ISSUE_VALID=1 → no scoreboard set; EX_MEM/ID_EX/IF_ID flushes=1. RST mid-pending → SB_PENDING=0, LONG_COUNT=0.

Source files
------------

// File: rtl/hazard_scoreboard_unit_pkg.sv
`default_nettype none
// ============================================================================
// hazard_scoreboard_unit_pkg : shared result/forward select encodings
// Rev 1.0
// ============================================================================
package hazard_scoreboard_unit_pkg;

  typedef enum logic [1:0] {
    RESULT_SEL_ALU      = 2'd0,
    RESULT_SEL_MEM_DATA = 2'd1,
    RESULT_SEL_PC_PLUS4 = 2'd2,
    RESULT_SEL_CSR      = 2'd3
  } result_sel_t;

  typedef enum logic [2:0] {
    NO_FORWARD_SEL             = 3'd0,
    FORWARD_SEL_MEM_ALU_RESULT = 3'd1,
    FORWARD_SEL_WB_ALU_RESULT  = 3'd2,
    FORWARD_SEL_WB_LOAD_RDATA  = 3'd3
  } forward_sel_t;

  typedef enum logic [1:0] {
    ID_FWD_NONE = 2'd0,
    ID_FWD_WB   = 2'd1,
    ID_FWD_LONG = 2'd2
  } id_fwd_sel_t;

endpackage
`default_nettype wire

// File: rtl/hazard_scoreboard_unit_if.sv
`default_nettype none
// ============================================================================
// hazard_scoreboard_unit_if : pipeline <-> hazard unit signal bundle
// Rev 1.0
// ============================================================================
interface hazard_scoreboard_unit_if
  import hazard_scoreboard_unit_pkg::*;
#(
  parameter int NUM_REGS   = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 3
);
  logic [REG_ADDR_W-1:0] id_rs1_addr;
  logic [REG_ADDR_W-1:0] id_rs2_addr;
  logic [REG_ADDR_W-1:0] id_rd_addr;
  logic                  id_is_long_op;
  logic [REG_ADDR_W-1:0] ex_rs1_addr;
  logic [REG_ADDR_W-1:0] ex_rs2_addr;
  logic [REG_ADDR_W-1:0] ex_rd_addr;
  logic [REG_ADDR_W-1:0] mem_rd_addr;
  logic [REG_ADDR_W-1:0] wb_rd_addr;
  result_sel_t           ex_result_sel;
  result_sel_t           mem_result_sel;
  result_sel_t           wb_result_sel;
  logic                  ex_is_pc_redirect;
  logic                  ex_trap_valid;
  logic                  mem_trap_valid;
  logic                  wb_trap_valid;
  logic                  wishbone_busy;
  logic                  long_issue_valid;
  logic [REG_ADDR_W-1:0] long_issue_rd;
  logic                  long_done_valid;
  logic [REG_ADDR_W-1:0] long_done_rd;

  forward_sel_t          ex_forward_a;
  forward_sel_t          ex_forward_b;
  id_fwd_sel_t           id_forward_a;
  id_fwd_sel_t           id_forward_b;
  logic                  if_id_flush;
  logic                  id_ex_flush;
  logic                  ex_mem_flush;
  logic                  mem_wb_flush;
  logic                  if_id_stall;
  logic                  id_ex_stall;
  logic                  ex_mem_stall;
  logic                  mem_wb_stall;
  logic [NUM_REGS-1:0]   sb_pending;
  logic [CNT_W-1:0]      long_count;
  logic                  bus_timeout;

  modport master (
    output id_rs1_addr, id_rs2_addr, id_rd_addr, id_is_long_op,
           ex_rs1_addr, ex_rs2_addr, ex_rd_addr, mem_rd_addr, wb_rd_addr,
           ex_result_sel, mem_result_sel, wb_result_sel,
           ex_is_pc_redirect, ex_trap_valid, mem_trap_valid, wb_trap_valid,
           wishbone_busy, long_issue_valid, long_issue_rd,
           long_done_valid, long_done_rd,
    input  ex_forward_a, ex_forward_b, id_forward_a, id_forward_b,
           if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
           if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall,
           sb_pending, long_count, bus_timeout
  );

  modport slave (
    input  id_rs1_addr, id_rs2_addr, id_rd_addr, id_is_long_op,
           ex_rs1_addr, ex_rs2_addr, ex_rd_addr, mem_rd_addr, wb_rd_addr,
           ex_result_sel, mem_result_sel, wb_result_sel,
           ex_is_pc_redirect, ex_trap_valid, mem_trap_valid, wb_trap_valid,
           wishbone_busy, long_issue_valid, long_issue_rd,
           long_done_valid, long_done_rd,
    output ex_forward_a, ex_forward_b, id_forward_a, id_forward_b,
           if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
           if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall,
           sb_pending, long_count, bus_timeout
  );

endinterface
`default_nettype wire

// File: rtl/hazard_scoreboard_unit_scoreboard.sv
`default_nettype none
// ============================================================================
// hazard_scoreboard_unit_scoreboard : pending-write bits and long-op counter
// Rev 1.0
// ============================================================================
module hazard_scoreboard_unit_scoreboard #(
  parameter int NUM_REGS    = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int MAX_PENDING = 4,
  parameter int CNT_W       = 3
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  i_issue_ok,
  input  wire logic [REG_ADDR_W-1:0] i_issue_rd,
  input  wire logic                  i_done_valid,
  input  wire logic [REG_ADDR_W-1:0] i_done_rd,
  output logic [NUM_REGS-1:0]        o_pending,
  output logic [NUM_REGS-1:0]        o_eff_pending,
  output logic [CNT_W-1:0]           o_long_count,
  output logic                       o_full
);

  localparam logic [CNT_W-1:0] c_max_pending = CNT_W'(MAX_PENDING);

  logic [NUM_REGS-1:0] r_pending;
  logic [CNT_W-1:0]    r_count;
  logic [NUM_REGS-1:0] w_done_clr;
  logic [NUM_REGS-1:0] w_issue_set;
  logic [NUM_REGS-1:0] w_eff_pending;
  logic                w_done_hit;

  always_comb begin
    w_done_clr  = '0;
    w_issue_set = '0;
    if (i_done_valid) w_done_clr[i_done_rd] = 1'b1;
    if (i_issue_ok)   w_issue_set[i_issue_rd] = 1'b1;
    // x0 can never be a pending destination
    w_issue_set[0] = 1'b0;
  end

  assign w_eff_pending = r_pending & ~w_done_clr;
  assign w_done_hit    = i_done_valid & r_pending[i_done_rd];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= '0;
      r_count   <= '0;
    end else begin
      r_pending <= w_eff_pending | w_issue_set;
      r_count   <= r_count + CNT_W'(i_issue_ok) - CNT_W'(w_done_hit);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (r_count <= c_max_pending);
  end

  assign o_pending     = r_pending;
  assign o_eff_pending = w_eff_pending;
  assign o_long_count  = r_count;
  assign o_full        = (r_count == c_max_pending);

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard_unit.sv
`default_nettype none
// ============================================================================
// hazard_scoreboard_unit : stall/flush/forward network, long-op scoreboard, bus watchdog
// Rev 1.0
// ============================================================================
module hazard_scoreboard_unit
  import hazard_scoreboard_unit_pkg::*;
#(
  parameter int NUM_REGS           = 32,
  parameter int REG_ADDR_W         = 5,
  parameter int MAX_PENDING        = 4,
  parameter int BUS_TIMEOUT_CYCLES = 1024
) (
  input  wire logic clk,
  input  wire logic rst,
  hazard_scoreboard_unit_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_PENDING + 1);

  typedef logic [REG_ADDR_W-1:0] addr_t;

  function automatic forward_sel_t f_ex_fwd(input addr_t rs, input addr_t mem_rd,
                                            input addr_t wb_rd, input result_sel_t wb_sel);
    if (rs == '0)     return NO_FORWARD_SEL;
    if (rs == mem_rd) return FORWARD_SEL_MEM_ALU_RESULT;
    if (rs == wb_rd)  return (wb_sel == RESULT_SEL_MEM_DATA) ? FORWARD_SEL_WB_LOAD_RDATA
                                                              : FORWARD_SEL_WB_ALU_RESULT;
    return NO_FORWARD_SEL;
  endfunction

  function automatic id_fwd_sel_t f_id_fwd(input addr_t rs, input logic done_valid,
                                           input addr_t done_rd, input addr_t wb_rd);
    if (rs == '0)                      return ID_FWD_NONE;
    if (done_valid && (rs == done_rd)) return ID_FWD_LONG;
    if (rs == wb_rd)                   return ID_FWD_WB;
    return ID_FWD_NONE;
  endfunction

  logic [NUM_REGS-1:0] w_pending;
  logic [NUM_REGS-1:0] w_eff_pending;
  logic [CNT_W-1:0]    w_long_count;
  logic                w_full;
  logic                w_load_use;
  logic                w_sb_hazard;
  logic                w_issue_ok;
  logic                w_mem_wb_stall;
  logic                w_ex_mem_stall;
  logic                w_id_ex_stall;
  logic                w_mem_wb_trap;
  logic                w_ex_mem_flush;
  logic                w_unused;

  assign w_load_use = (bus.ex_result_sel == RESULT_SEL_MEM_DATA) &
                      (((bus.id_rs1_addr != '0) & (bus.id_rs1_addr == bus.ex_rd_addr)) |
                       ((bus.id_rs2_addr != '0) & (bus.id_rs2_addr == bus.ex_rd_addr)));

  // Scoreboard terms are masked during reset; the pipeline-only terms stay live
  assign w_sb_hazard = ~rst &
                       (((bus.id_rs1_addr != '0) & w_eff_pending[bus.id_rs1_addr]) |
                        ((bus.id_rs2_addr != '0) & w_eff_pending[bus.id_rs2_addr]) |
                        ((bus.id_rd_addr  != '0) & w_eff_pending[bus.id_rd_addr])  |
                        (bus.id_is_long_op & w_full));

  assign w_mem_wb_stall = bus.wishbone_busy;
  assign w_ex_mem_stall = bus.wishbone_busy | w_mem_wb_stall;
  assign w_id_ex_stall  = w_ex_mem_stall;
  assign w_mem_wb_trap  = bus.mem_trap_valid | bus.wb_trap_valid;
  assign w_ex_mem_flush = w_mem_wb_trap;

  assign bus.mem_wb_stall = w_mem_wb_stall;
  assign bus.ex_mem_stall = w_ex_mem_stall;
  assign bus.id_ex_stall  = w_id_ex_stall;
  assign bus.if_id_stall  = w_load_use | w_sb_hazard | w_id_ex_stall;

  assign bus.if_id_flush  = bus.ex_is_pc_redirect | bus.ex_trap_valid | w_mem_wb_trap;
  // A held ID leaves a bubble behind it unless the whole back end is frozen
  assign bus.id_ex_flush  = (bus.ex_is_pc_redirect & ~w_ex_mem_stall) | w_mem_wb_trap |
                            ((w_load_use | w_sb_hazard) & ~w_id_ex_stall);
  assign bus.ex_mem_flush = w_ex_mem_flush;
  assign bus.mem_wb_flush = bus.wb_trap_valid;

  assign bus.ex_forward_a = f_ex_fwd(bus.ex_rs1_addr, bus.mem_rd_addr, bus.wb_rd_addr, bus.wb_result_sel);
  assign bus.ex_forward_b = f_ex_fwd(bus.ex_rs2_addr, bus.mem_rd_addr, bus.wb_rd_addr, bus.wb_result_sel);
  assign bus.id_forward_a = f_id_fwd(bus.id_rs1_addr, bus.long_done_valid, bus.long_done_rd, bus.wb_rd_addr);
  assign bus.id_forward_b = f_id_fwd(bus.id_rs2_addr, bus.long_done_valid, bus.long_done_rd, bus.wb_rd_addr);

  assign w_issue_ok = bus.long_issue_valid & (bus.long_issue_rd != '0) &
                      ~w_ex_mem_stall & ~w_ex_mem_flush;

  hazard_scoreboard_unit_scoreboard #(
    .NUM_REGS    (NUM_REGS),
    .REG_ADDR_W  (REG_ADDR_W),
    .MAX_PENDING (MAX_PENDING),
    .CNT_W       (CNT_W)
  ) u_scoreboard (
    .clk           (clk),
    .rst           (rst),
    .i_issue_ok    (w_issue_ok),
    .i_issue_rd    (bus.long_issue_rd),
    .i_done_valid  (bus.long_done_valid),
    .i_done_rd     (bus.long_done_rd),
    .o_pending     (w_pending),
    .o_eff_pending (w_eff_pending),
    .o_long_count  (w_long_count),
    .o_full        (w_full)
  );

  assign bus.sb_pending = w_pending;
  assign bus.long_count = w_long_count;

  generate
    if (BUS_TIMEOUT_CYCLES > 0) begin : g_wdog
      localparam int WD_W = $clog2(BUS_TIMEOUT_CYCLES + 1);
      localparam logic [WD_W-1:0] c_wd_limit    = WD_W'(BUS_TIMEOUT_CYCLES);
      localparam logic [WD_W-1:0] c_wd_limit_m1 = WD_W'(BUS_TIMEOUT_CYCLES - 1);

      logic [WD_W-1:0] r_wd_cnt;
      logic            r_timeout;

      // Counter saturates at the limit so the pulse fires once per busy episode
      always_ff @(posedge clk) begin
        if (rst) begin
          r_wd_cnt  <= '0;
          r_timeout <= 1'b0;
        end else begin
          r_timeout <= bus.wishbone_busy & (r_wd_cnt == c_wd_limit_m1);
          if (!bus.wishbone_busy)
            r_wd_cnt <= '0;
          else if (r_wd_cnt != c_wd_limit)
            r_wd_cnt <= r_wd_cnt + WD_W'(1);
        end
      end

      assign bus.bus_timeout = r_timeout;
    end else begin : g_no_wdog
      assign bus.bus_timeout = 1'b0;
    end
  endgenerate

  assign w_unused = ^bus.mem_result_sel;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard_unit.sv
`default_nettype none
// ============================================================================
// tb_hazard_scoreboard_unit : directed self-checking bench
// Rev 1.0
// ============================================================================
module tb_hazard_scoreboard_unit;
  import hazard_scoreboard_unit_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  hazard_scoreboard_unit_if #(.NUM_REGS(32), .REG_ADDR_W(5), .CNT_W(3)) hsu_if ();

  hazard_scoreboard_unit #(
    .NUM_REGS           (32),
    .REG_ADDR_W         (5),
    .MAX_PENDING        (4),
    .BUS_TIMEOUT_CYCLES (1024)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (hsu_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    hsu_if.id_rs1_addr       = '0;
    hsu_if.id_rs2_addr       = '0;
    hsu_if.id_rd_addr        = '0;
    hsu_if.id_is_long_op     = 1'b0;
    hsu_if.ex_rs1_addr       = '0;
    hsu_if.ex_rs2_addr       = '0;
    hsu_if.ex_rd_addr        = '0;
    hsu_if.mem_rd_addr       = '0;
    hsu_if.wb_rd_addr        = '0;
    hsu_if.ex_result_sel     = RESULT_SEL_ALU;
    hsu_if.mem_result_sel    = RESULT_SEL_ALU;
    hsu_if.wb_result_sel     = RESULT_SEL_ALU;
    hsu_if.ex_is_pc_redirect = 1'b0;
    hsu_if.ex_trap_valid     = 1'b0;
    hsu_if.mem_trap_valid    = 1'b0;
    hsu_if.wb_trap_valid     = 1'b0;
    hsu_if.wishbone_busy     = 1'b0;
    hsu_if.long_issue_valid  = 1'b0;
    hsu_if.long_issue_rd     = '0;
    hsu_if.long_done_valid   = 1'b0;
    hsu_if.long_done_rd      = '0;
  endtask

  task automatic issue(input logic [4:0] rd);
    hsu_if.long_issue_valid = 1'b1;
    hsu_if.long_issue_rd    = rd;
  endtask

  task automatic done(input logic [4:0] rd);
    hsu_if.long_done_valid = 1'b1;
    hsu_if.long_done_rd    = rd;
  endtask

  initial begin
    int pulses;
    int pulse_at;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    idle();
    tick();
    tick();
    check_eq("rst_pending", hsu_if.sb_pending, 32'h0);
    check_eq("rst_count", 32'(hsu_if.long_count), 32'd0);
    check_eq("rst_timeout", 32'(hsu_if.bus_timeout), 32'd0);
    rst = 1'b0;
    tick();

    // RAW on a pending MDU destination, resolved by same-cycle done forward
    issue(5'd5);
    tick();
    idle();
    hsu_if.id_rs1_addr = 5'd5;
    #1;
    check_eq("raw_pending", hsu_if.sb_pending, 32'h0000_0020);
    check_eq("raw_count", 32'(hsu_if.long_count), 32'd1);
    check_eq("raw_stall", 32'(hsu_if.if_id_stall), 32'd1);
    check_eq("raw_bubble", 32'(hsu_if.id_ex_flush), 32'd1);
    done(5'd5);
    hsu_if.id_rs2_addr = 5'd4;
    hsu_if.wb_rd_addr  = 5'd4;
    #1;
    check_eq("done_stall", 32'(hsu_if.if_id_stall), 32'd0);
    check_eq("done_fwd_a", 32'(hsu_if.id_forward_a), 32'd2);
    check_eq("wb_fwd_b", 32'(hsu_if.id_forward_b), 32'd1);
    check_eq("done_noflush", 32'(hsu_if.id_ex_flush), 32'd0);
    tick();
    idle();
    #1;
    check_eq("done_clear", hsu_if.sb_pending, 32'h0);
    check_eq("done_count", 32'(hsu_if.long_count), 32'd0);

    // Fill to MAX_PENDING, then a further long op in ID must wait
    for (int r = 1; r <= 4; r++) begin
      issue(5'(r));
      tick();
    end
    idle();
    #1;
    check_eq("full_count", 32'(hsu_if.long_count), 32'd4);
    check_eq("full_pending", hsu_if.sb_pending, 32'h0000_001E);
    hsu_if.id_is_long_op = 1'b1;
    hsu_if.id_rd_addr    = 5'd10;
    #1;
    check_eq("full_stall", 32'(hsu_if.if_id_stall), 32'd1);
    done(5'd2);
    #1;
    check_eq("full_stall_done", 32'(hsu_if.if_id_stall), 32'd1);
    tick();
    hsu_if.long_done_valid = 1'b0;
    #1;
    check_eq("full_count_dec", 32'(hsu_if.long_count), 32'd3);
    check_eq("full_released", 32'(hsu_if.if_id_stall), 32'd0);
    idle();
    done(5'd1); tick();
    done(5'd3); tick();
    done(5'd4); tick();
    idle();
    #1;
    check_eq("drain_count", 32'(hsu_if.long_count), 32'd0);

    // Same-cycle issue+done on one register; done on a non-pending register
    issue(5'd7);
    tick();
    issue(5'd7);
    done(5'd7);
    tick();
    idle();
    #1;
    check_eq("setwins_pending", hsu_if.sb_pending, 32'h0000_0080);
    check_eq("setwins_count", 32'(hsu_if.long_count), 32'd1);
    done(5'd9);
    tick();
    idle();
    #1;
    check_eq("stray_pending", hsu_if.sb_pending, 32'h0000_0080);
    check_eq("stray_count", 32'(hsu_if.long_count), 32'd1);
    done(5'd7);
    tick();
    idle();
    #1;
    check_eq("x7_clear", 32'(hsu_if.long_count), 32'd0);

    // Load-use, then forwarding priority from MEM/WB
    hsu_if.ex_result_sel = RESULT_SEL_MEM_DATA;
    hsu_if.ex_rd_addr    = 5'd3;
    hsu_if.id_rs2_addr   = 5'd3;
    #1;
    check_eq("lu_stall", 32'(hsu_if.if_id_stall), 32'd1);
    check_eq("lu_bubble", 32'(hsu_if.id_ex_flush), 32'd1);
    tick();
    idle();
    hsu_if.wb_rd_addr    = 5'd3;
    hsu_if.wb_result_sel = RESULT_SEL_MEM_DATA;
    hsu_if.ex_rs2_addr   = 5'd3;
    #1;
    check_eq("fwd_wb_load", 32'(hsu_if.ex_forward_b), 32'(FORWARD_SEL_WB_LOAD_RDATA));
    hsu_if.mem_rd_addr = 5'd3;
    #1;
    check_eq("fwd_mem_prio", 32'(hsu_if.ex_forward_b), 32'(FORWARD_SEL_MEM_ALU_RESULT));
    hsu_if.mem_rd_addr   = 5'd0;
    hsu_if.wb_result_sel = RESULT_SEL_ALU;
    #1;
    check_eq("fwd_wb_alu", 32'(hsu_if.ex_forward_b), 32'(FORWARD_SEL_WB_ALU_RESULT));
    hsu_if.wb_rd_addr  = 5'd0;
    hsu_if.mem_rd_addr = 5'd0;
    hsu_if.ex_rs1_addr = 5'd0;
    #1;
    check_eq("fwd_x0", 32'(hsu_if.ex_forward_a), 32'(NO_FORWARD_SEL));
    idle();

    // Bus watchdog: one pulse on the 1024th busy cycle, frozen back end
    pulses   = 0;
    pulse_at = 0;
    hsu_if.wishbone_busy = 1'b1;
    for (int i = 1; i <= 1030; i++) begin
      tick();
      if (hsu_if.bus_timeout) begin
        pulses++;
        pulse_at = i;
      end
      if (i == 10) begin
        hsu_if.ex_is_pc_redirect = 1'b1;
        issue(5'd12);
        #1;
        check_eq("busy_redir_noflush", 32'(hsu_if.id_ex_flush), 32'd0);
        check_eq("busy_redir_ifid", 32'(hsu_if.if_id_flush), 32'd1);
        check_eq("busy_stall", 32'(hsu_if.if_id_stall), 32'd1);
      end
      if (i == 11) begin
        hsu_if.ex_is_pc_redirect = 1'b0;
        hsu_if.long_issue_valid  = 1'b0;
      end
    end
    check_eq("wd_pulses", 32'(pulses), 32'd1);
    check_eq("wd_pulse_at", 32'(pulse_at), 32'd1024);
    check_eq("busy_no_issue", hsu_if.sb_pending, 32'h0);
    idle();
    tick();
    check_eq("wd_idle", 32'(hsu_if.bus_timeout), 32'd0);

    // Trap in MEM blocks the issue and flushes the front
    hsu_if.mem_trap_valid = 1'b1;
    issue(5'd6);
    #1;
    check_eq("trap_ifid", 32'(hsu_if.if_id_flush), 32'd1);
    check_eq("trap_idex", 32'(hsu_if.id_ex_flush), 32'd1);
    check_eq("trap_exmem", 32'(hsu_if.ex_mem_flush), 32'd1);
    check_eq("trap_memwb", 32'(hsu_if.mem_wb_flush), 32'd0);
    tick();
    idle();
    #1;
    check_eq("trap_pending", hsu_if.sb_pending, 32'h0);
    check_eq("trap_count", 32'(hsu_if.long_count), 32'd0);

    // Reset with ops in flight
    issue(5'd8);
    tick();
    issue(5'd9);
    tick();
    idle();
    #1;
    check_eq("pre_rst_count", 32'(hsu_if.long_count), 32'd2);
    rst = 1'b1;
    hsu_if.id_rs1_addr = 5'd8;
    #1;
    check_eq("rst_gate_stall", 32'(hsu_if.if_id_stall), 32'd0);
    tick();
    rst = 1'b0;
    idle();
    #1;
    check_eq("midrst_pending", hsu_if.sb_pending, 32'h0);
    check_eq("midrst_count", 32'(hsu_if.long_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
